// File: rtl/fptd_iteration_controller.sv
// Frame sequencer for the fully-parallel turbo decoder array: load, clear,
// alternating odd/even half-iterations, error-count capture, then completion.
module fptd_iteration_controller #(
    parameter int CW  = 7,
    parameter int FCW = 16
) (
    input  logic           Clock_i,
    input  logic           nReset_i,
    input  logic           Start_i,
    input  logic [CW-1:0]  Num_Half_Iter_i,
    input  logic           Abort_i,
    output logic           Load_Input_o,
    output logic           nClear_o,
    output logic           Enable_Odd_o,
    output logic           Enable_Even_o,
    output logic           Enable_Term_o,
    output logic           Enable_Error_Counter_o,
    output logic           Busy_o,
    output logic           Done_o,
    output logic [CW-1:0]  Half_Iter_Count_o,
    output logic [FCW-1:0] Frame_Count_o
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CLEAR = 3'd2,
        ITER  = 3'd3,
        COUNT = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  target_q, target_d;
    logic [CW-1:0]  halfIter_q, halfIter_d;
    logic [FCW-1:0] frames_q, frames_d;

    logic load_q, load_d;
    logic nClear_q, nClear_d;
    logic oddEn_q, oddEn_d;
    logic evenEn_q, evenEn_d;
    logic termEn_q, termEn_d;
    logic errEn_q, errEn_d;
    logic busy_q, busy_d;
    logic done_q, done_d;

    // Outputs are decoded from the next state so every output is a flop.
    always_comb begin
        state_d    = state_q;
        target_d   = target_q;
        halfIter_d = halfIter_q;
        frames_d   = frames_q;

        unique case (state_q)
            IDLE: begin
                if (Start_i && !Abort_i) begin
                    state_d  = LOAD;
                    target_d = (Num_Half_Iter_i == '0) ? CW'(1) : Num_Half_Iter_i;
                end
            end
            LOAD:  state_d = CLEAR;
            CLEAR: state_d = ITER;
            ITER: begin
                if (halfIter_q + CW'(1) == target_q) begin
                    state_d = COUNT;
                end
            end
            COUNT: state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && Abort_i) begin
            state_d = IDLE;
        end

        if (state_d == CLEAR) begin
            halfIter_d = '0;
        end else if (state_q == ITER && state_d != IDLE) begin
            halfIter_d = halfIter_q + CW'(1);
        end

        if (state_d == DONE) begin
            frames_d = frames_q + FCW'(1);
        end

        load_d   = (state_d == LOAD);
        nClear_d = (state_d != CLEAR);
        termEn_d = (state_d == ITER);
        oddEn_d  = (state_d == ITER) && !halfIter_d[0];
        evenEn_d = (state_d == ITER) && halfIter_d[0];
        errEn_d  = (state_d == COUNT);
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
    end

    always_ff @(posedge Clock_i) begin
        if (!nReset_i) begin
            state_q    <= IDLE;
            target_q   <= CW'(1);
            halfIter_q <= '0;
            frames_q   <= '0;
            load_q     <= 1'b0;
            nClear_q   <= 1'b1;
            oddEn_q    <= 1'b0;
            evenEn_q   <= 1'b0;
            termEn_q   <= 1'b0;
            errEn_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            target_q   <= target_d;
            halfIter_q <= halfIter_d;
            frames_q   <= frames_d;
            load_q     <= load_d;
            nClear_q   <= nClear_d;
            oddEn_q    <= oddEn_d;
            evenEn_q   <= evenEn_d;
            termEn_q   <= termEn_d;
            errEn_q    <= errEn_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign Load_Input_o           = load_q;
    assign nClear_o               = nClear_q;
    assign Enable_Odd_o           = oddEn_q;
    assign Enable_Even_o          = evenEn_q;
    assign Enable_Term_o          = termEn_q;
    assign Enable_Error_Counter_o = errEn_q;
    assign Busy_o                 = busy_q;
    assign Done_o                 = done_q;
    assign Half_Iter_Count_o      = halfIter_q;
    assign Frame_Count_o          = frames_q;

endmodule
